echo_delay_scheduler: RTL and testbench
=======================================

# echo_delay_scheduler

Sequencer that time-shares one single-port synchronous RAM between the write and read traffic of the stereo echo delay line. It runs in the `clk256` domain between the deserialized I2S input samples and the echo mixer/S/PDIF path. For each accepted stereo sample it does the following:

- reads the left and right samples stored `delay_samples` frames earlier;
- overwrites those locations with the new samples;
- advances the circular write pointer;
- presents the delayed pair with a one-cycle valid strobe.

## Interface
- `audio_width`, 16, bits per channel sample
- `delay_samples`, 2048, delay length in stereo frames; any value ≥ 2
- `addr_width`, `$clog2(delay_samples)+1`, RAM word-address width (frame pointer plus channel bit)

- `clk256`  in  1  system clock, 256×Fs
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  one-cycle strobe: `in_l`/`in_r` hold a new frame
- `in_l`  in  audio_width  left input sample, two's complement
- `in_r`  in  audio_width  right input sample
- `ram_addr`  out  addr_width  RAM address = {frame pointer, channel}; channel 0 = L, 1 = R
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  audio_width  RAM write data
- `ram_rdata`  in  audio_width  RAM read data, valid the cycle after the address is presented
- `out_valid`  out  1  one-cycle strobe: delayed pair valid
- `out_l`  out  audio_width  delayed left sample
- `out_r`  out  audio_width  delayed right sample
- `busy`  out  1  high while not IDLE
- `overrun`  out  1  one-cycle pulse: `in_valid` arrived while busy, frame dropped

## Operation
- States: IDLE → RD_L → RD_R → WR_L → WR_R → IDLE. `out_valid` is registered, asserted in the first cycle after WR_R.
- IDLE: `ram_we`=0. On `in_valid`, latch `in_l`/`in_r` and go to RD_L; otherwise stay.
- RD_L: `ram_addr`={ptr,0}, `ram_we`=0.
- RD_R: `ram_addr`={ptr,1}, `ram_we`=0. Capture `ram_rdata` into delayed L.
- WR_L: `ram_addr`={ptr,0}, `ram_we`=1, `ram_wdata`=latched L. Capture `ram_rdata` into delayed R.
- WR_R: `ram_addr`={ptr,1}, `ram_we`=1, `ram_wdata`=latched R.
  - ptr ← (ptr == delay_samples−1) ? 0 : ptr+1.
  - On that wrap, set the sticky `primed` flag.
- Next cycle, `out_valid`=1 and `out_l`/`out_r` update together:
  - before `primed`, both are 0, because RAM contents are undefined after power-up;
  - after `primed`, they are the captured delayed values.
- `out_l`/`out_r` hold their values between strobes.
- `in_valid` while state ≠ IDLE: the frame is ignored, `overrun` pulses next cycle, and the in-flight sequence is unaffected.
- `ram_addr`, `ram_we` and `ram_wdata` are decoded from registered state only; there is no combinational path from `in_valid`.
- In IDLE: `ram_addr` = {ptr,0}, `ram_wdata` = 0.
- Read-before-write within a frame: the old contents of {ptr,x} are returned before they are overwritten.

## Timing
- Reset values:
  - state=IDLE, ptr=0, primed=0;
  - `ram_addr`=0, `ram_we`=0, `ram_wdata`=0;
  - `out_valid`=0, `out_l`=0, `out_r`=0;
  - `busy`=0, `overrun`=0.
- Cycle sequence, with `in_valid` sampled high in IDLE at edge E0:
  - RD_L during cycle 1, RD_R cycle 2, WR_L cycle 3, WR_R cycle 4;
  - `out_valid` high during cycle 5;
  - back in IDLE during cycle 5, so a new `in_valid` is accepted during cycle 5.
- Minimum accepted frame spacing: 5 cycles. The nominal 256 cycles per frame gives a large margin.
- `busy` is high during cycles 1–4.
- `in_valid` exactly in cycle 5 coincides with `out_valid`; it is accepted with no `overrun`.
- Reset asserted mid-sequence: state returns to IDLE immediately and asynchronously.
  - `ram_we` drops to 0 at once.
  - Any partial write is lost, ptr=0, primed=0.
- Echo delay: the output of frame n carries the input of frame n−`delay_samples`.

## Test plan
- Reset idle: hold `reset`, then release with no `in_valid` → all outputs 0, `ram_we` never 1.
- Single frame (`delay_samples`=4): `in_valid` with L=0x1234, R=0xABCD →
  - addresses 0,1,0,1 in cycles 1–4, with `ram_we`=0,0,1,1;
  - write data 0x1234, 0xABCD;
  - `out_valid` in cycle 5 with out=0/0 (unprimed).
- Echo delay (`delay_samples`=4, behavioural RAM): frames k=0..9 with L=k, R=0x100+k, spaced 256 cycles →
  - frames 0–3 output 0/0;
  - frame n≥4 outputs L=n−4, R=0x100+n−4;
  - ptr wraps 3→0.
- Back-to-back: `in_valid` exactly every 5 cycles for 8 frames → all accepted, no `overrun`, correct delayed data.
- Overrun: `in_valid` in cycle 2 of a sequence →
  - `overrun` pulses in cycle 3;
  - the original sequence completes unchanged;
  - ptr advances once.
- Reset mid-write: assert `reset` during WR_L →
  - `ram_we` falls immediately, ptr=0, primed=0;
  - the next frame after release writes addresses 0/1.

Source files
------------

// File: rtl/echo_delay_scheduler.sv
// Time-shares one single-port RAM between the read and write traffic of the stereo echo delay line.
// Each accepted frame reads the old L/R pair at the write pointer, overwrites it, then strobes the delayed pair.
module echo_delay_scheduler #(
    parameter int unsigned audio_width   = 16,
    parameter int unsigned delay_samples = 2048,
    parameter int unsigned addr_width    = $clog2(delay_samples) + 1
) (
    input  logic                   clk256,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [audio_width-1:0] in_l,
    input  logic [audio_width-1:0] in_r,
    output logic [addr_width-1:0]  ram_addr,
    output logic                   ram_we,
    output logic [audio_width-1:0] ram_wdata,
    input  logic [audio_width-1:0] ram_rdata,
    output logic                   out_valid,
    output logic [audio_width-1:0] out_l,
    output logic [audio_width-1:0] out_r,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned ptr_width = $clog2(delay_samples);
    localparam logic [ptr_width-1:0] ptr_last = ptr_width'(delay_samples - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_L = 3'd1,
        RD_R = 3'd2,
        WR_L = 3'd3,
        WR_R = 3'd4
    } state_t;

    state_t                 state, state_d;
    logic [ptr_width-1:0]   ptr, ptr_d;
    logic                   primed, primed_d;
    logic [audio_width-1:0] lat_l, lat_l_d;
    logic [audio_width-1:0] lat_r, lat_r_d;
    logic [audio_width-1:0] dly_l, dly_l_d;
    logic [audio_width-1:0] dly_r, dly_r_d;
    logic [addr_width-1:0]  ram_addr_d;
    logic                   ram_we_d;
    logic [audio_width-1:0] ram_wdata_d;
    logic                   out_valid_d;
    logic [audio_width-1:0] out_l_d;
    logic [audio_width-1:0] out_r_d;
    logic                   busy_d;
    logic                   overrun_d;

    // Next-state logic; RAM controls are decoded from the next state so they are registered in step with it.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        primed_d    = primed;
        lat_l_d     = lat_l;
        lat_r_d     = lat_r;
        dly_l_d     = dly_l;
        dly_r_d     = dly_r;
        out_valid_d = 1'b0;
        out_l_d     = out_l;
        out_r_d     = out_r;
        overrun_d   = in_valid && (state != IDLE);
        ram_wdata_d = '0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    lat_l_d = in_l;
                    lat_r_d = in_r;
                    state_d = RD_L;
                end
            end
            RD_L: state_d = RD_R;
            RD_R: begin
                dly_l_d = ram_rdata;
                state_d = WR_L;
            end
            WR_L: begin
                dly_r_d = ram_rdata;
                state_d = WR_R;
            end
            WR_R: begin
                if (ptr == ptr_last) begin
                    ptr_d    = '0;
                    primed_d = 1'b1;
                end else begin
                    ptr_d = ptr + ptr_width'(1);
                end
                // Until the line has been filled once the RAM holds power-up garbage, so emit silence.
                out_valid_d = 1'b1;
                out_l_d     = primed ? dly_l : '0;
                out_r_d     = primed ? dly_r : '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ram_we_d   = (state_d == WR_L) || (state_d == WR_R);
        ram_addr_d = addr_width'({ptr_d, ((state_d == RD_R) || (state_d == WR_R))});
        if (state_d == WR_L) ram_wdata_d = lat_l;
        if (state_d == WR_R) ram_wdata_d = lat_r;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            primed    <= 1'b0;
            lat_l     <= '0;
            lat_r     <= '0;
            dly_l     <= '0;
            dly_r     <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            primed    <= primed_d;
            lat_l     <= lat_l_d;
            lat_r     <= lat_r_d;
            dly_l     <= dly_l_d;
            dly_r     <= dly_r_d;
            ram_addr  <= ram_addr_d;
            ram_we    <= ram_we_d;
            ram_wdata <= ram_wdata_d;
            out_valid <= out_valid_d;
            out_l     <= out_l_d;
            out_r     <= out_r_d;
            busy      <= busy_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_echo_delay_scheduler.sv
// Directed bench for echo_delay_scheduler with a 4-frame delay and a behavioural read-before-write RAM.
module tb_echo_delay_scheduler;

    localparam int unsigned aw = 16;
    localparam int unsigned ds = 4;
    localparam int unsigned adw = 3;

    logic           clk256 = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [aw-1:0]  in_l, in_r;
    logic [adw-1:0] ram_addr;
    logic           ram_we;
    logic [aw-1:0]  ram_wdata;
    logic [aw-1:0]  ram_rdata;
    logic           out_valid;
    logic [aw-1:0]  out_l, out_r;
    logic           busy, overrun;

    int tests = 0;
    int fails = 0;

    logic [aw-1:0] mem [0:7];

    echo_delay_scheduler #(
        .audio_width(aw),
        .delay_samples(ds),
        .addr_width(adw)
    ) dut (
        .clk256(clk256),
        .reset(reset),
        .in_valid(in_valid),
        .in_l(in_l),
        .in_r(in_r),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .out_valid(out_valid),
        .out_l(out_l),
        .out_r(out_r),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk256 = ~clk256;

    // Synchronous single-port RAM: read returns the old contents when reading and writing the same word.
    always @(posedge clk256) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic [aw-1:0] l;
        logic [aw-1:0] r;
        logic [1:0]    p;
        logic [aw-1:0] exp_l;
        logic [aw-1:0] exp_r;
        bit            spaced;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [1:0] p, input logic ch);
        return 32'({p, ch});
    endfunction

    // Drives one frame at a negedge and checks cycles 1..5; returns at the cycle-5 negedge.
    task automatic send_frame(input int id, input logic [aw-1:0] l, input logic [aw-1:0] r,
                              input logic [1:0] p, input logic [aw-1:0] el, input logic [aw-1:0] er);
        in_l = l; in_r = r; in_valid = 1'b1;
        @(negedge clk256);
        in_valid = 1'b0; in_l = '0; in_r = '0;
        check($sformatf("f%0d_c1_addr", id), 32'(ram_addr), addr_of(p, 1'b0));
        check($sformatf("f%0d_c1_we", id), 32'(ram_we), 32'd0);
        check($sformatf("f%0d_c1_busy", id), 32'(busy), 32'd1);
        check($sformatf("f%0d_c1_overrun", id), 32'(overrun), 32'd0);
        @(negedge clk256);
        check($sformatf("f%0d_c2_addr", id), 32'(ram_addr), addr_of(p, 1'b1));
        check($sformatf("f%0d_c2_we", id), 32'(ram_we), 32'd0);
        @(negedge clk256);
        check($sformatf("f%0d_c3_addr", id), 32'(ram_addr), addr_of(p, 1'b0));
        check($sformatf("f%0d_c3_we", id), 32'(ram_we), 32'd1);
        check($sformatf("f%0d_c3_wdata", id), 32'(ram_wdata), 32'(l));
        @(negedge clk256);
        check($sformatf("f%0d_c4_addr", id), 32'(ram_addr), addr_of(p, 1'b1));
        check($sformatf("f%0d_c4_we", id), 32'(ram_we), 32'd1);
        check($sformatf("f%0d_c4_wdata", id), 32'(ram_wdata), 32'(r));
        @(negedge clk256);
        check($sformatf("f%0d_c5_out_valid", id), 32'(out_valid), 32'd1);
        check($sformatf("f%0d_c5_out_l", id), 32'(out_l), 32'(el));
        check($sformatf("f%0d_c5_out_r", id), 32'(out_r), 32'(er));
        check($sformatf("f%0d_c5_busy", id), 32'(busy), 32'd0);
        check($sformatf("f%0d_c5_overrun", id), 32'(overrun), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk256);
        reset = 1'b1;
        repeat (2) @(negedge clk256);
        reset = 1'b0;
        @(negedge clk256);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
        reset = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0;

        // 10 frames spaced ~256 cycles, then 8 frames back-to-back; delayed by 4 frames.
        for (int k = 0; k < 18; k++) begin
            vecs[k].l      = aw'(k);
            vecs[k].r      = aw'(16'h100 + k);
            vecs[k].p      = 2'(k % 4);
            vecs[k].exp_l  = (k >= 4) ? aw'(k - 4) : '0;
            vecs[k].exp_r  = (k >= 4) ? aw'(16'h100 + k - 4) : '0;
            vecs[k].spaced = (k < 10);
        end

        // Reset idle
        repeat (3) @(negedge clk256);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk256);
            check($sformatf("idle_we_c%0d", c), 32'(ram_we), 32'd0);
        end
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_l", 32'(out_l), 32'd0);
        check("rst_out_r", 32'(out_r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Single unprimed frame
        send_frame(100, 16'h1234, 16'hABCD, 2'd0, 16'h0000, 16'h0000);
        @(negedge clk256);
        check("single_out_valid_drop", 32'(out_valid), 32'd0);
        check("single_idle_addr", 32'(ram_addr), addr_of(2'd1, 1'b0));

        // Echo delay, then back-to-back
        do_reset();
        for (int k = 0; k < 18; k++) begin
            send_frame(k, vecs[k].l, vecs[k].r, vecs[k].p, vecs[k].exp_l, vecs[k].exp_r);
            if (vecs[k].spaced) repeat (251) @(negedge clk256);
        end

        // Overrun: second in_valid during RD_R is dropped (ptr is at 2)
        in_l = 16'hAAAA; in_r = 16'hBBBB; in_valid = 1'b1;
        @(negedge clk256);
        in_valid = 1'b0;
        @(negedge clk256);
        in_l = 16'h5555; in_r = 16'h6666; in_valid = 1'b1;
        @(negedge clk256);
        in_valid = 1'b0;
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_c3_addr", 32'(ram_addr), addr_of(2'd2, 1'b0));
        check("ovr_c3_wdata", 32'(ram_wdata), 32'h0000AAAA);
        @(negedge clk256);
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        check("ovr_c4_addr", 32'(ram_addr), addr_of(2'd2, 1'b1));
        check("ovr_c4_wdata", 32'(ram_wdata), 32'h0000BBBB);
        @(negedge clk256);
        check("ovr_out_valid", 32'(out_valid), 32'd1);
        check("ovr_out_l", 32'(out_l), 32'd14);
        check("ovr_out_r", 32'(out_r), 32'h10E);
        send_frame(19, 16'h0C0C, 16'h0D0D, 2'd3, 16'd15, 16'h10F);

        // Reset asserted during WR_L (ptr is at 0, RAM word 0 holds frame 16)
        repeat (3) @(negedge clk256);
        in_l = 16'h7777; in_r = 16'h8888; in_valid = 1'b1;
        @(negedge clk256);
        in_valid = 1'b0;
        repeat (2) @(negedge clk256);
        check("mid_we_before", 32'(ram_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_we_drop", 32'(ram_we), 32'd0);
        check("mid_addr", 32'(ram_addr), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        @(negedge clk256);
        reset = 1'b0;
        repeat (2) @(negedge clk256);
        check("mid_mem0_kept", 32'(mem[0]), 32'd16);
        send_frame(200, 16'h4321, 16'h8765, 2'd0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
